// File: rtl/dds_parallel_writer_if.sv
// Bundle between the DDS register slave (master side) and the AD9854 parallel writer (slave side).
// Carries the register snapshot inputs, the CEN/READY handshake and the AD9854 pins.
interface dds_parallel_writer_if;
  logic        CEN;
  logic [15:0] F1H;
  logic [31:0] F1L;
  logic [15:0] F2H;
  logic [31:0] F2L;
  logic [15:0] DFWH;
  logic [31:0] DFWL;
  logic [13:0] PTW1;
  logic [13:0] PTW2;
  logic [19:0] RAMPRATE;
  logic [2:0]  MODE;
  logic        TRAIANGLE;
  logic        PLLEN;
  logic        PLLRANGE;
  logic        OSK;
  logic [4:0]  CLKMUILT;

  logic [5:0]  DDS_A;
  logic [7:0]  DDS_D;
  logic        DDS_WRB;
  logic        DDS_RDB;
  logic        DDS_UDCLK;
  logic        BUSY;
  logic        READY;

  modport master (
    output CEN, F1H, F1L, F2H, F2L, DFWH, DFWL, PTW1, PTW2, RAMPRATE,
           MODE, TRAIANGLE, PLLEN, PLLRANGE, OSK, CLKMUILT,
    input  DDS_A, DDS_D, DDS_WRB, DDS_RDB, DDS_UDCLK, BUSY, READY
  );

  modport slave (
    input  CEN, F1H, F1L, F2H, F2L, DFWH, DFWL, PTW1, PTW2, RAMPRATE,
           MODE, TRAIANGLE, PLLEN, PLLRANGE, OSK, CLKMUILT,
    output DDS_A, DDS_D, DDS_WRB, DDS_RDB, DDS_UDCLK, BUSY, READY
  );
endinterface

// File: rtl/dds_parallel_writer.sv
// Snapshots the DDS register set on CEN and writes it into the AD9854 over the parallel port,
// 29 bytes in ascending address order, then pulses I/O UD CLK and returns a one-cycle READY.
module dds_parallel_writer #(
  parameter int WR_SETUP_CYCLES = 1,
  parameter int WR_LOW_CYCLES   = 2,
  parameter int WR_HOLD_CYCLES  = 1,
  parameter int UD_CYCLES       = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  dds_parallel_writer_if.slave  bus
);

  localparam logic [7:0] SETUP_LAST = 8'(WR_SETUP_CYCLES);
  localparam logic [7:0] LOW_LAST   = 8'(WR_LOW_CYCLES);
  localparam logic [7:0] HOLD_LAST  = 8'(WR_HOLD_CYCLES);
  localparam logic [7:0] UD_LAST    = 8'(UD_CYCLES);
  localparam logic [4:0] LAST_BYTE  = 5'd28;

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HOLD, UD, DONE, WAITREL
  } state_t;

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [4:0]  idx_reg;

  logic [47:0] f1_reg;
  logic [47:0] f2_reg;
  logic [47:0] dfw_reg;
  logic [13:0] ptw1_reg;
  logic [13:0] ptw2_reg;
  logic [19:0] ramp_reg;
  logic [2:0]  mode_reg;
  logic        tri_reg;
  logic        pllen_reg;
  logic        pllrange_reg;
  logic        osk_reg;
  logic [4:0]  clkm_reg;

  logic [5:0]  a_reg;
  logic [7:0]  d_reg;
  logic        wrb_reg;
  logic        udclk_reg;
  logic        busy_reg;
  logic        ready_reg;

  logic [7:0]  map_bytes [32];
  logic [4:0]  idx_sel;
  logic [5:0]  addr_sel;
  logic [7:0]  byte_sel;

  // Byte image of the shadow set, indexed by byte number n (not by chip address).
  assign map_bytes[0] = {2'b00, ptw1_reg[13:8]};
  assign map_bytes[1] = ptw1_reg[7:0];
  assign map_bytes[2] = {2'b00, ptw2_reg[13:8]};
  assign map_bytes[3] = ptw2_reg[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_freq
      assign map_bytes[4 + gi]  = f1_reg[47 - 8*gi -: 8];
      assign map_bytes[10 + gi] = f2_reg[47 - 8*gi -: 8];
      assign map_bytes[16 + gi] = dfw_reg[47 - 8*gi -: 8];
    end
    for (gi = 29; gi < 32; gi++) begin : g_pad
      assign map_bytes[gi] = 8'h00;
    end
  endgenerate

  assign map_bytes[22] = {4'b0000, ramp_reg[19:16]};
  assign map_bytes[23] = ramp_reg[15:8];
  assign map_bytes[24] = ramp_reg[7:0];
  assign map_bytes[25] = 8'h10;
  assign map_bytes[26] = {1'b0, pllrange_reg, ~pllen_reg, clkm_reg};
  assign map_bytes[27] = {2'b00, tri_reg, 1'b0, mode_reg, 1'b0};
  assign map_bytes[28] = {2'b00, osk_reg, 5'b00000};

  // HOLD loads the next byte on its last edge, so look one index ahead there.
  always_comb begin
    idx_sel  = (state_reg == HOLD) ? idx_reg + 5'd1 : idx_reg;
    addr_sel = (idx_sel < 5'd22) ? {1'b0, idx_sel} : {1'b0, idx_sel} + 6'd4;
    byte_sel = map_bytes[idx_sel];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      idx_reg      <= 5'd0;
      f1_reg       <= 48'd0;
      f2_reg       <= 48'd0;
      dfw_reg      <= 48'd0;
      ptw1_reg     <= 14'd0;
      ptw2_reg     <= 14'd0;
      ramp_reg     <= 20'd0;
      mode_reg     <= 3'd0;
      tri_reg      <= 1'b0;
      pllen_reg    <= 1'b0;
      pllrange_reg <= 1'b0;
      osk_reg      <= 1'b0;
      clkm_reg     <= 5'd0;
      a_reg        <= 6'd0;
      d_reg        <= 8'd0;
      wrb_reg      <= 1'b1;
      udclk_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.CEN) begin
            f1_reg       <= {bus.F1H, bus.F1L};
            f2_reg       <= {bus.F2H, bus.F2L};
            dfw_reg      <= {bus.DFWH, bus.DFWL};
            ptw1_reg     <= bus.PTW1;
            ptw2_reg     <= bus.PTW2;
            ramp_reg     <= bus.RAMPRATE;
            mode_reg     <= bus.MODE;
            tri_reg      <= bus.TRAIANGLE;
            pllen_reg    <= bus.PLLEN;
            pllrange_reg <= bus.PLLRANGE;
            osk_reg      <= bus.OSK;
            clkm_reg     <= bus.CLKMUILT;
            idx_reg      <= 5'd0;
            cnt_reg      <= 8'd0;
            busy_reg     <= 1'b1;
            state_reg    <= SETUP;
          end
        end

        SETUP: begin
          // cnt_reg==0 only for byte 0: the shadow set is one edge old here.
          if (cnt_reg == 8'd0) begin
            a_reg <= addr_sel;
            d_reg <= byte_sel;
          end
          if (cnt_reg == SETUP_LAST) begin
            wrb_reg   <= 1'b0;
            cnt_reg   <= 8'd1;
            state_reg <= LOW;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        LOW: begin
          if (cnt_reg == LOW_LAST) begin
            wrb_reg   <= 1'b1;
            cnt_reg   <= 8'd1;
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            cnt_reg <= 8'd1;
            if (idx_reg == LAST_BYTE) begin
              udclk_reg <= 1'b1;
              state_reg <= UD;
            end else begin
              idx_reg   <= idx_reg + 5'd1;
              a_reg     <= addr_sel;
              d_reg     <= byte_sel;
              state_reg <= SETUP;
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        UD: begin
          if (cnt_reg == UD_LAST) begin
            udclk_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        DONE: begin
          ready_reg <= 1'b0;
          state_reg <= WAITREL;
        end

        WAITREL: begin
          if (!bus.CEN) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.DDS_A     = a_reg;
  assign bus.DDS_D     = d_reg;
  assign bus.DDS_WRB   = wrb_reg;
  assign bus.DDS_RDB   = 1'b1;
  assign bus.DDS_UDCLK = udclk_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.READY     = ready_reg;

endmodule

// File: tb/tb_dds_parallel_writer.sv
// Scoreboard bench for dds_parallel_writer: stimulus pushes expected writes/UDCLK/READY,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_dds_parallel_writer;
  localparam int S = 1;
  localparam int L = 2;
  localparam int H = 1;
  localparam int U = 4;
  localparam int B = S + L + H;

  logic CLK = 1'b0;
  logic RST;
  dds_parallel_writer_if bus();

  dds_parallel_writer #(
    .WR_SETUP_CYCLES(S), .WR_LOW_CYCLES(L), .WR_HOLD_CYCLES(H), .UD_CYCLES(U)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t  exp_wr[$];
  int   exp_ud[$];
  int   exp_rdy[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_count = 0;
  bit   abort_flag = 0;
  logic [7:0] wr_data [64];
  bit   written [64];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference byte map, written per chip address.
  function automatic logic [7:0] exp_byte(input logic [5:0] a);
    logic [47:0] f1;
    logic [47:0] f2;
    logic [47:0] dw;
    int ai;
    f1 = {bus.F1H, bus.F1L};
    f2 = {bus.F2H, bus.F2L};
    dw = {bus.DFWH, bus.DFWL};
    ai = int'(a);
    exp_byte = 8'h00;
    if (ai == 0)       exp_byte = {2'b00, bus.PTW1[13:8]};
    else if (ai == 1)  exp_byte = bus.PTW1[7:0];
    else if (ai == 2)  exp_byte = {2'b00, bus.PTW2[13:8]};
    else if (ai == 3)  exp_byte = bus.PTW2[7:0];
    else if (ai <= 9)  exp_byte = f1[8*(9-ai) +: 8];
    else if (ai <= 15) exp_byte = f2[8*(15-ai) +: 8];
    else if (ai <= 21) exp_byte = dw[8*(21-ai) +: 8];
    else begin
      case (ai)
        26: exp_byte = {4'h0, bus.RAMPRATE[19:16]};
        27: exp_byte = bus.RAMPRATE[15:8];
        28: exp_byte = bus.RAMPRATE[7:0];
        29: exp_byte = 8'h10;
        30: exp_byte = {1'b0, bus.PLLRANGE, ~bus.PLLEN, bus.CLKMUILT};
        31: exp_byte = {2'b00, bus.TRAIANGLE, 1'b0, bus.MODE, 1'b0};
        32: exp_byte = {2'b00, bus.OSK, 5'b0};
        default: exp_byte = 8'h00;
      endcase
    end
  endfunction

  // Monitor
  logic prev_wrb = 1'b1, prev_ud = 1'b0, prev_ready = 1'b0;
  int   low_cnt = 0, ud_cnt = 0;
  always @(negedge CLK) begin
    wr_t e;
    if (RST) begin
      prev_wrb = 1'b1; prev_ud = 1'b0; prev_ready = 1'b0;
      low_cnt = 0; ud_cnt = 0;
    end else begin
      if (prev_wrb && !bus.DDS_WRB) begin
        wr_count++;
        written[bus.DDS_A] = 1'b1;
        wr_data[bus.DDS_A] = bus.DDS_D;
        low_cnt = 0;
        check("busy_during_write", 32'(bus.BUSY), 1);
        if (exp_wr.size() == 0) begin
          check("write_was_expected", 32'(exp_wr.size()), 1);
        end else begin
          e = exp_wr.pop_front();
          $display("write addr 0x%02h data 0x%02h cycle %0d", bus.DDS_A, bus.DDS_D, cyc);
          check("write_addr", 32'(bus.DDS_A), 32'(e.a));
          check("write_data", 32'(bus.DDS_D), 32'(e.d));
          check("write_fall_cycle", cyc, e.c);
        end
      end
      if (!bus.DDS_WRB) low_cnt++;
      if (!prev_wrb && bus.DDS_WRB && !abort_flag) check("wrb_low_width", low_cnt, L);

      if (!prev_ud && bus.DDS_UDCLK) begin
        ud_cnt = 0;
        if (exp_ud.size() == 0) check("udclk_was_expected", 32'(exp_ud.size()), 1);
        else check("udclk_rise_cycle", cyc, exp_ud.pop_front());
      end
      if (bus.DDS_UDCLK) ud_cnt++;
      if (prev_ud && !bus.DDS_UDCLK) check("udclk_width", ud_cnt, U);

      if (prev_ready) check("ready_one_cycle", 32'(bus.READY), 0);
      if (bus.READY && !prev_ready) begin
        check("busy_low_at_ready", 32'(bus.BUSY), 0);
        if (exp_rdy.size() == 0) check("ready_was_expected", 32'(exp_rdy.size()), 1);
        else check("ready_cycle", cyc, exp_rdy.pop_front());
      end

      prev_wrb = bus.DDS_WRB; prev_ud = bus.DDS_UDCLK; prev_ready = bus.READY;
    end
  end

  // Called at a negedge with the DUT idle; edge k is the next posedge.
  task automatic start_xfer(output int k);
    wr_t e;
    int  a;
    k = cyc + 1;
    wr_count = 0;
    for (int i = 0; i < 64; i++) written[i] = 1'b0;
    for (int n = 0; n < 29; n++) begin
      a = (n < 22) ? n : n + 4;
      e.a = 6'(a);
      e.d = exp_byte(6'(a));
      e.c = k + 1 + B*n + S;
      exp_wr.push_back(e);
    end
    exp_ud.push_back(k + 1 + 29*B);
    exp_rdy.push_back(k + 1 + 29*B + U);
    bus.CEN = 1'b1;
    $display("start transfer at edge %0d", k);
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!bus.READY && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("ready_before_timeout", 32'(bus.READY), 1);
    check("ready_latency", cyc - k, 121);
  endtask

  task automatic check_no_reserved;
    check("no_write_0x16_0x19", 32'(written[22] | written[23] | written[24] | written[25]), 0);
    check("write_count", wr_count, 29);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    RST = 1'b1;
    bus.CEN = 1'b0;
    bus.F1H = 16'h1234; bus.F1L = 32'h56789ABC;
    bus.F2H = 16'hA1B2; bus.F2L = 32'hC3D4E5F6;
    bus.DFWH = 16'h0F0E; bus.DFWL = 32'h0D0C0B0A;
    bus.PTW1 = 14'h2ABC; bus.PTW2 = 14'h1357;
    bus.RAMPRATE = 20'hABCDE;
    bus.MODE = 3'd2; bus.TRAIANGLE = 1'b1; bus.PLLEN = 1'b1; bus.PLLRANGE = 1'b1;
    bus.OSK = 1'b1; bus.CLKMUILT = 5'd10;

    // Reset values before any clock edge
    #2;
    check("rst_wrb", 32'(bus.DDS_WRB), 1);
    check("rst_rdb", 32'(bus.DDS_RDB), 1);
    check("rst_udclk", 32'(bus.DDS_UDCLK), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_ready", 32'(bus.READY), 0);
    check("rst_addr", 32'(bus.DDS_A), 0);
    check("rst_data", 32'(bus.DDS_D), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Transfer 1: frequency and control encoding
    start_xfer(k);
    wait_ready(k);
    bus.CEN = 1'b0;
    check_no_reserved();
    check("addr04_f1_msb", 32'(wr_data[6'h04]), 32'h12);
    check("addr09_f1_lsb", 32'(wr_data[6'h09]), 32'hBC);
    check("addr00_ptw1_hi", 32'(wr_data[6'h00]), 32'h2A);
    check("addr1a_ramp_hi", 32'(wr_data[6'h1A]), 32'h0A);
    check("addr1d_comp_pd", 32'(wr_data[6'h1D]), 32'h10);
    check("addr1e_pll", 32'(wr_data[6'h1E]), 32'h4A);
    check("addr1f_mode", 32'(wr_data[6'h1F]), 32'h24);
    check("addr20_osk", 32'(wr_data[6'h20]), 32'h20);
    repeat (4) @(negedge CLK);

    // Transfer 2: snapshot, F2L changes during byte 3; CEN then held 50 cycles past READY
    bus.F2L = 32'h11223344;
    start_xfer(k);
    repeat (14) @(negedge CLK);
    bus.F2L = 32'hFFFFFFFF;
    wait_ready(k);
    check("addr0f_snapshot", 32'(wr_data[6'h0F]), 32'h44);
    repeat (50) @(negedge CLK);
    check("no_retrigger_writes", wr_count, 29);
    check("no_retrigger_busy", 32'(bus.BUSY), 0);
    bus.CEN = 1'b0;
    repeat (4) @(negedge CLK);

    // Transfer 3: re-raised CEN, alternate control bits
    bus.PLLEN = 1'b0; bus.PLLRANGE = 1'b0; bus.CLKMUILT = 5'd4;
    bus.MODE = 3'd5; bus.TRAIANGLE = 1'b0; bus.OSK = 1'b0;
    start_xfer(k);
    wait_ready(k);
    bus.CEN = 1'b0;
    check_no_reserved();
    check("addr0f_new_f2l", 32'(wr_data[6'h0F]), 32'hFF);
    check("addr1e_pll_alt", 32'(wr_data[6'h1E]), 32'h24);
    check("addr1f_mode_alt", 32'(wr_data[6'h1F]), 32'h0A);
    check("addr20_osk_alt", 32'(wr_data[6'h20]), 32'h00);
    repeat (4) @(negedge CLK);

    // Transfer 4: reset during LOW of byte 10
    start_xfer(k);
    repeat (44) @(negedge CLK);
    check("wrb_low_byte10", 32'(bus.DDS_WRB), 0);
    check("addr_byte10", 32'(bus.DDS_A), 32'h0A);
    abort_flag = 1;
    #1 RST = 1'b1;
    bus.CEN = 1'b0;
    #1;
    check("abort_wrb_high", 32'(bus.DDS_WRB), 1);
    check("abort_busy_low", 32'(bus.BUSY), 0);
    check("abort_remaining_bytes", 32'(exp_wr.size()), 18);
    exp_wr.delete();
    exp_ud.delete();
    exp_rdy.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (150) @(negedge CLK);
    check("abort_no_udclk", 32'(bus.DDS_UDCLK), 0);
    check("abort_no_ready", 32'(bus.READY), 0);
    abort_flag = 0;

    // Transfer 5: full transfer after abort
    bus.F1H = 16'hFEDC; bus.F1L = 32'hBA987654;
    start_xfer(k);
    wait_ready(k);
    bus.CEN = 1'b0;
    check_no_reserved();
    check("addr04_after_abort", 32'(wr_data[6'h04]), 32'hFE);
    check("addr09_after_abort", 32'(wr_data[6'h09]), 32'h54);
    repeat (4) @(negedge CLK);
    check("queues_drained", 32'(exp_wr.size() + exp_ud.size() + exp_rdy.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
